// File: rtl/ram_pkg.sv
// Shared types and helpers for the handshaked dual-port RAM.
// Response payload is sized for the widest supported word; narrower instances zero-extend.
package ram_pkg;

  localparam int unsigned MAX_READ_LAT  = 2;
  localparam int unsigned RAM_MAX_BYTES = 8;
  localparam int unsigned RAM_MAX_WIDTH = RAM_MAX_BYTES * 8;

  typedef struct packed {
    logic [RAM_MAX_WIDTH-1:0] data;
    logic                     err;
  } ram_resp_t;

  function automatic logic [RAM_MAX_WIDTH-1:0] byte_merge(
    input logic [RAM_MAX_WIDTH-1:0] old_word,
    input logic [RAM_MAX_WIDTH-1:0] new_word,
    input logic [RAM_MAX_BYTES-1:0] be
  );
    logic [RAM_MAX_WIDTH-1:0] merged;
    for (int unsigned i = 0; i < RAM_MAX_BYTES; i++) begin
      merged[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_resp_fifo.sv
// Fall-through response FIFO: an arriving entry is presented the same cycle when the FIFO is empty.
module ram_resp_fifo
  import ram_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  ram_resp_t        in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output ram_resp_t        out_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ram_resp_t        store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count == '0);
  assign out_valid = in_valid || !empty;
  assign out_data  = empty ? in_data : store[rd_ptr];
  assign pop       = !empty && out_ready;
  // An entry consumed on arrival bypasses storage entirely.
  assign push      = in_valid && !(empty && out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/ram_dp_hs.sv
// Dual-port word RAM with valid/ready handshakes: port A R/W with byte enables, port B read-only.
// Define RAM_WR_FWD_EN to forward same-cycle port A write data to a colliding port B read.
module ram_dp_hs
  import ram_pkg::*;
#(
  parameter int unsigned BYTES    = 4,
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WIDTH    = BYTES * 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [BYTES-1:0]  a_we,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_resp_valid,
  input  logic              a_resp_ready,
  output logic [WIDTH-1:0]  a_rdata,
  output logic              a_err,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_resp_valid,
  input  logic              b_resp_ready,
  output logic [WIDTH-1:0]  b_rdata,
  output logic              b_err
);

  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FIFO_D = READ_LAT + 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_D + 1);
  localparam int unsigned OUT_W  = $clog2(MAX_READ_LAT + 2);

  if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_lat
    $fatal(1, "ram_dp_hs: READ_LAT must be 1 or 2");
  end
  if (WIDTH != BYTES * 8 || BYTES > RAM_MAX_BYTES) begin : g_bad_width
    $fatal(1, "ram_dp_hs: WIDTH must equal BYTES*8 and BYTES must not exceed RAM_MAX_BYTES");
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic             a_fire, b_fire;
  logic             a_ok, b_ok;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic [WIDTH-1:0] a_rd_q, b_rd_q;
  logic             a_v1, b_v1;
  logic             a_err1, b_err1;
  ram_resp_t        a_s1, b_s1;
  logic             a_fin_v, b_fin_v;
  ram_resp_t        a_fin, b_fin;
  logic [OUT_W-1:0] a_pipe, b_pipe;
  logic             a_fov, b_fov;
  ram_resp_t        a_fout, b_fout;
  logic [FCNT_W-1:0] a_fcnt, b_fcnt;
  logic [OUT_W-1:0] a_out, b_out;

  assign a_fire = a_req_valid && a_req_ready;
  assign b_fire = b_req_valid && b_req_ready;
  assign a_ok   = (a_addr < ADDR_W'(DEPTH));
  assign b_ok   = (b_addr < ADDR_W'(DEPTH));
  assign a_idx  = a_ok ? a_addr[IDX_W-1:0] : '0;
  assign b_idx  = b_ok ? b_addr[IDX_W-1:0] : '0;

  // Array: byte-masked write on port A, registered read-first reads on both ports.
  always_ff @(posedge clk) begin
    if (a_fire && a_ok) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (a_we[i]) mem[a_idx][i*8 +: 8] <= a_wdata[i*8 +: 8];
      end
    end
    if (a_fire) a_rd_q <= mem[a_idx];
    if (b_fire) b_rd_q <= mem[b_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_v1   <= 1'b0;
      b_v1   <= 1'b0;
      a_err1 <= 1'b0;
      b_err1 <= 1'b0;
    end else begin
      a_v1   <= a_fire;
      b_v1   <= b_fire;
      a_err1 <= !a_ok;
      b_err1 <= !b_ok;
    end
  end

`ifdef RAM_WR_FWD_EN
  logic [BYTES-1:0] b_fwd_be1;
  logic [WIDTH-1:0] b_fwd_data1;

  // Merge is applied after the array register so the array read itself stays plain.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_fwd_be1   <= '0;
      b_fwd_data1 <= '0;
    end else if (b_fire) begin
      b_fwd_be1   <= (a_fire && a_ok && b_ok && (a_idx == b_idx)) ? a_we : '0;
      b_fwd_data1 <= a_wdata;
    end
  end
`endif

  always_comb begin
    a_s1      = '0;
    a_s1.err  = a_err1;
    a_s1.data = a_err1 ? '0 : RAM_MAX_WIDTH'(a_rd_q);
    b_s1      = '0;
    b_s1.err  = b_err1;
`ifdef RAM_WR_FWD_EN
    b_s1.data = b_err1 ? '0 : byte_merge(RAM_MAX_WIDTH'(b_rd_q), RAM_MAX_WIDTH'(b_fwd_data1),
                                         RAM_MAX_BYTES'(b_fwd_be1));
`else
    b_s1.data = b_err1 ? '0 : RAM_MAX_WIDTH'(b_rd_q);
`endif
  end

  if (READ_LAT == 2) begin : g_lat2
    logic      a_v2, b_v2;
    ram_resp_t a_r2, b_r2;

    always_ff @(posedge clk) begin
      if (rst) begin
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
        a_r2 <= '0;
        b_r2 <= '0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        a_r2 <= a_s1;
        b_r2 <= b_s1;
      end
    end

    assign a_fin_v = a_v2;
    assign b_fin_v = b_v2;
    assign a_fin   = a_r2;
    assign b_fin   = b_r2;
    assign a_pipe  = OUT_W'(a_v1) + OUT_W'(a_v2);
    assign b_pipe  = OUT_W'(b_v1) + OUT_W'(b_v2);
  end else begin : g_lat1
    assign a_fin_v = a_v1;
    assign b_fin_v = b_v1;
    assign a_fin   = a_s1;
    assign b_fin   = b_s1;
    assign a_pipe  = OUT_W'(a_v1);
    assign b_pipe  = OUT_W'(b_v1);
  end

  ram_resp_fifo #(.DEPTH(FIFO_D)) u_a_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_fin_v),
    .in_data   (a_fin),
    .out_valid (a_fov),
    .out_ready (a_resp_ready),
    .out_data  (a_fout),
    .count     (a_fcnt)
  );

  ram_resp_fifo #(.DEPTH(FIFO_D)) u_b_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_fin_v),
    .in_data   (b_fin),
    .out_valid (b_fov),
    .out_ready (b_resp_ready),
    .out_data  (b_fout),
    .count     (b_fcnt)
  );

  // Credits come only from registered state, so resp_ready never reaches req_ready.
  assign a_out = a_pipe + OUT_W'(a_fcnt);
  assign b_out = b_pipe + OUT_W'(b_fcnt);

  assign a_req_ready  = !rst && (a_out < OUT_W'(READ_LAT + 1));
  assign b_req_ready  = !rst && (b_out < OUT_W'(READ_LAT + 1));
  assign a_resp_valid = !rst && a_fov;
  assign b_resp_valid = !rst && b_fov;
  assign a_rdata      = a_resp_valid ? a_fout.data[WIDTH-1:0] : '0;
  assign b_rdata      = b_resp_valid ? b_fout.data[WIDTH-1:0] : '0;
  assign a_err        = a_resp_valid && a_fout.err;
  assign b_err        = b_resp_valid && b_fout.err;

  if (WIDTH < RAM_MAX_WIDTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{a_fout.data[RAM_MAX_WIDTH-1:WIDTH], b_fout.data[RAM_MAX_WIDTH-1:WIDTH]};
  end

endmodule

// File: tb/tb_ram_dp_hs.sv
// Directed bench for ram_dp_hs: one READ_LAT=1 and one READ_LAT=2 instance.
// Collision expectations follow RAM_WR_FWD_EN.
module tb_ram_dp_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RAM_WR_FWD_EN
  localparam logic [31:0] EXP_COLL1 = 32'hCAFEF00D;
  localparam logic [31:0] EXP_COLL2 = 32'hCAFE2222;
`else
  localparam logic [31:0] EXP_COLL1 = 32'h00000000;
  localparam logic [31:0] EXP_COLL2 = 32'hCAFEF00D;
`endif

  logic        rst1, rst2;
  logic        a1_req_valid, a1_req_ready, a1_resp_valid, a1_resp_ready, a1_err;
  logic [31:0] a1_addr, a1_wdata, a1_rdata;
  logic [3:0]  a1_we;
  logic        b1_req_valid, b1_req_ready, b1_resp_valid, b1_resp_ready, b1_err;
  logic [31:0] b1_addr, b1_rdata;
  logic        a2_req_valid, a2_req_ready, a2_resp_valid, a2_resp_ready, a2_err;
  logic [31:0] a2_addr, a2_wdata, a2_rdata;
  logic [3:0]  a2_we;
  logic        b2_req_valid, b2_req_ready, b2_resp_valid, b2_resp_ready, b2_err;
  logic [31:0] b2_addr, b2_rdata;

  ram_dp_hs #(.BYTES(4), .DEPTH(4096), .READ_LAT(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst1),
    .a_req_valid(a1_req_valid), .a_req_ready(a1_req_ready), .a_addr(a1_addr), .a_we(a1_we),
    .a_wdata(a1_wdata), .a_resp_valid(a1_resp_valid), .a_resp_ready(a1_resp_ready),
    .a_rdata(a1_rdata), .a_err(a1_err),
    .b_req_valid(b1_req_valid), .b_req_ready(b1_req_ready), .b_addr(b1_addr),
    .b_resp_valid(b1_resp_valid), .b_resp_ready(b1_resp_ready), .b_rdata(b1_rdata), .b_err(b1_err)
  );

  ram_dp_hs #(.BYTES(4), .DEPTH(4096), .READ_LAT(2), .ADDR_W(32)) dut2 (
    .clk(clk), .rst(rst2),
    .a_req_valid(a2_req_valid), .a_req_ready(a2_req_ready), .a_addr(a2_addr), .a_we(a2_we),
    .a_wdata(a2_wdata), .a_resp_valid(a2_resp_valid), .a_resp_ready(a2_resp_ready),
    .a_rdata(a2_rdata), .a_err(a2_err),
    .b_req_valid(b2_req_valid), .b_req_ready(b2_req_ready), .b_addr(b2_addr),
    .b_resp_valid(b2_resp_valid), .b_resp_ready(b2_resp_ready), .b_rdata(b2_rdata), .b_err(b2_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Port A op on dut1, entered at a negedge; response due one cycle after the fire.
  task automatic a1_op(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                       input bit chk_data, input logic [31:0] exp_d, input logic exp_e,
                       input string tag);
    chk({tag, "_rdy"}, 32'(a1_req_ready), 32'd1);
    a1_req_valid = 1'b1; a1_addr = addr; a1_we = we; a1_wdata = wd;
    @(negedge clk);
    a1_req_valid = 1'b0;
    chk({tag, "_vld"}, 32'(a1_resp_valid), 32'd1);
    if (chk_data) begin
      chk({tag, "_data"}, a1_rdata, exp_d);
      chk({tag, "_err"}, 32'(a1_err), 32'(exp_e));
    end
  endtask

  task automatic b1_op(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_e,
                       input string tag);
    chk({tag, "_rdy"}, 32'(b1_req_ready), 32'd1);
    b1_req_valid = 1'b1; b1_addr = addr;
    @(negedge clk);
    b1_req_valid = 1'b0;
    chk({tag, "_vld"}, 32'(b1_resp_valid), 32'd1);
    chk({tag, "_data"}, b1_rdata, exp_d);
    chk({tag, "_err"}, 32'(b1_err), 32'(exp_e));
  endtask

  // Port A op on dut2: nothing after one cycle, response after two.
  task automatic a2_op(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd,
                       input bit chk_data, input logic [31:0] exp_d, input string tag);
    chk({tag, "_rdy"}, 32'(a2_req_ready), 32'd1);
    a2_req_valid = 1'b1; a2_addr = addr; a2_we = we; a2_wdata = wd;
    @(negedge clk);
    a2_req_valid = 1'b0;
    chk({tag, "_early"}, 32'(a2_resp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(a2_resp_valid), 32'd1);
    if (chk_data) chk({tag, "_data"}, a2_rdata, exp_d);
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    a1_req_valid = 1'b0; a1_addr = '0; a1_we = '0; a1_wdata = '0; a1_resp_ready = 1'b1;
    b1_req_valid = 1'b0; b1_addr = '0; b1_resp_ready = 1'b1;
    a2_req_valid = 1'b0; a2_addr = '0; a2_we = '0; a2_wdata = '0; a2_resp_ready = 1'b1;
    b2_req_valid = 1'b0; b2_addr = '0; b2_resp_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_a_rdy",  32'(a1_req_ready),  32'd0);
    chk("rst_b_rdy",  32'(b1_req_ready),  32'd0);
    chk("rst_a_vld",  32'(a1_resp_valid), 32'd0);
    chk("rst_b_vld",  32'(b1_resp_valid), 32'd0);
    chk("rst_a_data", a1_rdata,           32'd0);
    chk("rst_a_err",  32'(a1_err),        32'd0);
    chk("rst2_a_rdy", 32'(a2_req_ready),  32'd0);
    chk("rst2_b_vld", 32'(b2_resp_valid), 32'd0);
    rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);

    // READ_LAT=1: read-first write response, then back-to-back read
    a1_op(32'd5, 4'hF, 32'h12345678, 1'b0, 32'd0, 1'b0, "init5");
    a1_op(32'd5, 4'hF, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0, "wr5");
    a1_op(32'd5, 4'h0, 32'd0,        1'b1, 32'hDEADBEEF, 1'b0, "rd5");

    // byte enables
    a1_op(32'd7, 4'hF,    32'h11223344, 1'b0, 32'd0, 1'b0, "init7");
    a1_op(32'd7, 4'b0101, 32'hAABBCCDD, 1'b1, 32'h11223344, 1'b0, "be_wr");
    a1_op(32'd7, 4'h0,    32'd0,        1'b1, 32'h11BB33DD, 1'b0, "be_rd");

    // out of range: 4096 aliases index 0 in the low bits, must not write
    a1_op(32'd0,    4'hF, 32'h0BADF00D, 1'b0, 32'd0, 1'b0, "init0");
    a1_op(32'd4096, 4'hF, 32'hFFFFFFFF, 1'b1, 32'd0, 1'b1, "oor_wr");
    a1_op(32'd0,    4'h0, 32'd0,        1'b1, 32'h0BADF00D, 1'b0, "oor_mem0");
    b1_op(32'd5000, 32'd0, 1'b1, "b_oor");
    b1_op(32'd5, 32'hDEADBEEF, 1'b0, "b_rd5");

    // collisions
    a1_op(32'd9, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0, "init9");
    a1_req_valid = 1'b1; a1_addr = 32'd9; a1_we = 4'hF; a1_wdata = 32'hCAFEF00D;
    b1_req_valid = 1'b1; b1_addr = 32'd9;
    @(negedge clk);
    a1_req_valid = 1'b0; b1_req_valid = 1'b0;
    chk("coll1_b_vld",  32'(b1_resp_valid), 32'd1);
    chk("coll1_b_data", b1_rdata, EXP_COLL1);
    chk("coll1_a_data", a1_rdata, 32'd0);
    a1_req_valid = 1'b1; a1_addr = 32'd9; a1_we = 4'b0011; a1_wdata = 32'h11112222;
    b1_req_valid = 1'b1; b1_addr = 32'd9;
    @(negedge clk);
    a1_req_valid = 1'b0; b1_req_valid = 1'b0;
    chk("coll2_b_data", b1_rdata, EXP_COLL2);
    chk("coll2_a_data", a1_rdata, 32'hCAFEF00D);
    b1_op(32'd9, 32'hCAFE2222, 1'b0, "coll_after");

    // READ_LAT=2: preload words 0..3
    for (int i = 0; i < 4; i++) begin
      a2_op(32'(i), 4'hF, 32'hA0 + 32'(i), 1'b0, 32'd0, "pre");
    end

    // backpressure on port B
    b2_resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", 32'(b2_req_ready), 32'd1);
      b2_req_valid = 1'b1; b2_addr = 32'(i);
      @(negedge clk);
    end
    b2_addr = 32'd3;
    chk("bp_full_rdy",  32'(b2_req_ready),  32'd0);
    chk("bp_vld0",      32'(b2_resp_valid), 32'd1);
    chk("bp_data0",     b2_rdata,           32'hA0);
    @(negedge clk);
    chk("bp_full_rdy2", 32'(b2_req_ready),  32'd0);
    chk("bp_hold0",     b2_rdata,           32'hA0);
    b2_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_data1",     b2_rdata,           32'hA1);
    chk("bp_rdy_again", 32'(b2_req_ready),  32'd1);
    @(negedge clk);
    b2_req_valid = 1'b0;
    chk("bp_data2",     b2_rdata,           32'hA2);
    @(negedge clk);
    chk("bp_vld3",      32'(b2_resp_valid), 32'd1);
    chk("bp_data3",     b2_rdata,           32'hA3);
    @(negedge clk);
    chk("bp_idle",      32'(b2_resp_valid), 32'd0);

    // reset with two reads outstanding on port A
    a2_resp_ready = 1'b0;
    a2_req_valid = 1'b1; a2_we = 4'h0; a2_addr = 32'd0;
    @(negedge clk);
    a2_addr = 32'd1;
    @(negedge clk);
    a2_req_valid = 1'b0;
    chk("mr_pending", 32'(a2_resp_valid), 32'd1);
    rst2 = 1'b1;
    #1;
    chk("mr_rst_vld",  32'(a2_resp_valid), 32'd0);
    chk("mr_rst_rdy",  32'(a2_req_ready),  32'd0);
    chk("mr_rst_data", a2_rdata,           32'd0);
    @(negedge clk);
    chk("mr_rst_vld2", 32'(a2_resp_valid), 32'd0);
    rst2 = 1'b0;
    a2_resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_no_stale", 32'(a2_resp_valid), 32'd0);
    end
    a2_op(32'd1, 4'h0, 32'd0, 1'b1, 32'hA1, "mr_post");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
